// File: rtl/clock_pkg.sv
// Shared definitions for the alarm path: FSM state encoding, BCD field
// offsets within the 24-bit {Ht,Hu,Mt,Mu,St,Su} time word, and helpers.
package clock_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRing   = 2'd1,
        StSnooze = 2'd2
    } alarm_state_e;

    // Bit offset of each BCD digit in the time word
    localparam int unsigned BcdHt = 20;
    localparam int unsigned BcdHu = 16;
    localparam int unsigned BcdMt = 12;
    localparam int unsigned BcdMu = 8;
    localparam int unsigned BcdSt = 4;
    localparam int unsigned BcdSu = 0;

    // HH:MM portion of a time word
    function automatic logic [15:0] bcd_hhmm(input logic [23:0] t);
        return t[BcdHt+3:BcdMu];
    endfunction

    // True when the seconds field reads 00
    function automatic logic bcd_sec_zero(input logic [23:0] t);
        return t[BcdSt+3:BcdSu] == 8'h00;
    endfunction

endpackage

// File: rtl/alarm_ctrl_if.sv
// Time/alarm/button inputs and buzzer/status outputs of the alarm controller.
// master: the stage driving time, alarm setting and buttons; slave: alarm_ctrl.
interface alarm_ctrl_if;

    logic        sec_tick;
    logic [23:0] now;
    logic [23:0] alarm;
    logic        alarm_en;
    logic        stop;
    logic        snooze;
    logic        buzzer;
    logic        ringing;
    logic        snoozing;

    modport master (
        output sec_tick, now, alarm, alarm_en, stop, snooze,
        input  buzzer, ringing, snoozing
    );

    modport slave (
        input  sec_tick, now, alarm, alarm_en, stop, snooze,
        output buzzer, ringing, snoozing
    );

endinterface

// File: rtl/alarm_ctrl_sec_countdown.sv
// Loadable seconds down-counter. load has priority over tick; last flags a
// count of 1 so the owner can leave the state before the counter reaches 0.
module sec_countdown #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         last
);

    logic [W-1:0] cnt_q;

    // Counter register: reload or decrement once per gated tick
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (tick) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign last = (cnt_q == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm controller: detects the first second of the alarm minute, rings the
// buzzer, supports snooze/stop and auto-timeout.
// Optional feature macro ALARM_BEEP_EN: buzzer beeps 1 s on / 1 s off while
// ringing instead of a steady tone.
module alarm_ctrl
    import clock_pkg::*;
#(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 300
) (
    input logic         clk,
    input logic         rst,
    alarm_ctrl_if.slave bus
);

    localparam int unsigned RingW = $clog2(RING_SEC + 1);
    localparam int unsigned SnzW  = $clog2(SNOOZE_SEC + 1);

    localparam logic [RingW-1:0] RingLoad = RingW'(RING_SEC);
    localparam logic [SnzW-1:0]  SnzLoad  = SnzW'(SNOOZE_SEC);

    alarm_state_e state_q, state_d;
    logic         match, match_q, trigger;
    logic         ring_load, ring_tick, ring_last;
    logic         snz_load, snz_tick, snz_last;

    assign match = bus.alarm_en
                 & (bcd_hhmm(bus.now) == bcd_hhmm(bus.alarm))
                 & bcd_sec_zero(bus.now);
    assign trigger = match & ~match_q;

    // Match history for rising-edge detection (one trigger per minute)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and counter controls; priority ~alarm_en > stop > snooze > expiry
    always_comb begin
        state_d   = state_q;
        ring_load = 1'b0;
        ring_tick = 1'b0;
        snz_load  = 1'b0;
        snz_tick  = 1'b0;
        if (!bus.alarm_en) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (trigger) begin
                        state_d   = StRing;
                        ring_load = 1'b1;
                    end
                end
                StRing: begin
                    // A trigger here is ignored so the countdown is not reloaded
                    if (bus.stop) begin
                        state_d = StIdle;
                    end else if (bus.snooze) begin
                        state_d  = StSnooze;
                        snz_load = 1'b1;
                    end else if (bus.sec_tick) begin
                        if (ring_last) begin
                            state_d = StIdle;
                        end else begin
                            ring_tick = 1'b1;
                        end
                    end
                end
                StSnooze: begin
                    if (bus.stop) begin
                        state_d = StIdle;
                    end else if (bus.sec_tick) begin
                        if (snz_last) begin
                            state_d   = StRing;
                            ring_load = 1'b1;
                        end else begin
                            snz_tick = 1'b1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    sec_countdown #(
        .W (RingW)
    ) u_ring_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (ring_load),
        .load_val (RingLoad),
        .tick     (ring_tick),
        .last     (ring_last)
    );

    sec_countdown #(
        .W (SnzW)
    ) u_snz_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (snz_load),
        .load_val (SnzLoad),
        .tick     (snz_tick),
        .last     (snz_last)
    );

    assign bus.ringing  = (state_q == StRing);
    assign bus.snoozing = (state_q == StSnooze);

`ifdef ALARM_BEEP_EN
    logic beep_q;

    // Beep phase: on at RING entry, toggles per second, off outside RING
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beep_q <= 1'b0;
        end else if (state_d != StRing) begin
            beep_q <= 1'b0;
        end else if (state_q != StRing) begin
            beep_q <= 1'b1;
        end else if (bus.sec_tick) begin
            beep_q <= ~beep_q;
        end
    end

    assign bus.buzzer = beep_q;
`else
    assign bus.buzzer = bus.ringing;
`endif

endmodule

// File: tb/tb_alarm_ctrl.sv
// Bench for alarm_ctrl with RING_SEC=3, SNOOZE_SEC=5: directed scenarios with
// literal expectations plus a per-cycle comparison against a behavioural model.
module tb_alarm_ctrl;

    localparam int unsigned RingSec = 3;
    localparam int unsigned SnzSec  = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int checks   = 0;
    int failures = 0;

    alarm_ctrl_if bus ();

    alarm_ctrl #(
        .RING_SEC   (RingSec),
        .SNOOZE_SEC (SnzSec)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0=idle, 1=ringing, 2=snoozing, seconds remaining
    int m_mode = 0;
    int m_rem  = 0;
    bit m_beep = 1'b0;
    bit m_prev = 1'b0;

    // Model update on every clock edge, asynchronous reset
    always @(posedge clk or posedge rst) begin : model
        int md;
        int rem;
        bit bp;
        bit m;
        bit trig;
        if (rst) begin
            m_mode <= 0;
            m_rem  <= 0;
            m_beep <= 1'b0;
            m_prev <= 1'b0;
        end else begin
            md   = m_mode;
            rem  = m_rem;
            bp   = m_beep;
            m    = bus.alarm_en && (bus.now[23:8] == bus.alarm[23:8]) && (bus.now[7:0] == 8'h00);
            trig = m && !m_prev;
            if (!bus.alarm_en) begin
                md = 0;
            end else if (md == 0) begin
                if (trig) begin
                    md  = 1;
                    rem = RingSec;
                    bp  = 1'b1;
                end
            end else if (md == 1) begin
                if (bus.stop) begin
                    md = 0;
                end else if (bus.snooze) begin
                    md  = 2;
                    rem = SnzSec;
                end else if (bus.sec_tick) begin
                    rem = rem - 1;
                    bp  = !bp;
                    if (rem == 0) md = 0;
                end
            end else begin
                if (bus.stop) begin
                    md = 0;
                end else if (bus.sec_tick) begin
                    rem = rem - 1;
                    if (rem == 0) begin
                        md  = 1;
                        rem = RingSec;
                        bp  = 1'b1;
                    end
                end
            end
            m_mode <= md;
            m_rem  <= rem;
            m_beep <= bp;
            m_prev <= m;
        end
    end

    task automatic chk(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin : compare
        logic exp_ring;
        logic exp_snz;
        logic exp_buz;
        exp_ring = (m_mode == 1);
        exp_snz  = (m_mode == 2);
`ifdef ALARM_BEEP_EN
        exp_buz = exp_ring && m_beep;
`else
        exp_buz = exp_ring;
`endif
        chk("model_ringing", bus.ringing, exp_ring);
        chk("model_snoozing", bus.snoozing, exp_snz);
        chk("model_buzzer", bus.buzzer, exp_buz);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick();
        bus.sec_tick = 1'b1;
        step(1);
        bus.sec_tick = 1'b0;
    endtask

    task automatic press_stop();
        bus.stop = 1'b1;
        step(1);
        bus.stop = 1'b0;
    endtask

    task automatic press_snooze();
        bus.snooze = 1'b1;
        step(1);
        bus.snooze = 1'b0;
    endtask

    // Walk now from 07:14:59 to 07:15:00 to produce a fresh match edge
    task automatic arm();
        bus.now = 24'h071459;
        step(1);
        bus.now = 24'h071500;
        step(1);
    endtask

    task automatic outs(input string name, input logic r, input logic s, input logic b);
        chk({name, "_ringing"}, bus.ringing, r);
        chk({name, "_snoozing"}, bus.snoozing, s);
        chk({name, "_buzzer"}, bus.buzzer, b);
    endtask

    initial begin
        bus.sec_tick = 1'b0;
        bus.now      = 24'h071459;
        bus.alarm    = 24'h071500;
        bus.alarm_en = 1'b1;
        bus.stop     = 1'b0;
        bus.snooze   = 1'b0;
        step(2);
        outs("reset", 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(1);

        // 1: minute match rings on the next clock with buzzer on
        bus.now = 24'h071500;
        step(1);
        outs("trigger", 1'b1, 1'b0, 1'b1);

        // 2 / 6: timeout on 3rd tick, beep pattern, no re-trigger while now is held
        tick();
`ifdef ALARM_BEEP_EN
        outs("tick1", 1'b1, 1'b0, 1'b0);
`else
        outs("tick1", 1'b1, 1'b0, 1'b1);
`endif
        tick();
        outs("tick2", 1'b1, 1'b0, 1'b1);
        tick();
        outs("timeout", 1'b0, 1'b0, 1'b0);
        step(3);
        outs("no_retrigger", 1'b0, 1'b0, 1'b0);

        // 3: snooze, re-ring after 5 ticks, stop during snooze
        arm();
        chk("rearm_ringing", bus.ringing, 1'b1);
        press_snooze();
        outs("snooze", 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        outs("snooze_4ticks", 1'b0, 1'b1, 1'b0);
        tick();
        outs("rering", 1'b1, 1'b0, 1'b1);
        press_snooze();
        chk("snooze2", bus.snoozing, 1'b1);
        press_snooze();
        chk("snooze_ignored_in_snooze", bus.snoozing, 1'b1);
        press_stop();
        outs("stop_in_snooze", 1'b0, 1'b0, 1'b0);

        // 4: stop beats snooze; alarm_en low cancels snooze
        arm();
        bus.stop   = 1'b1;
        bus.snooze = 1'b1;
        step(1);
        bus.stop   = 1'b0;
        bus.snooze = 1'b0;
        outs("stop_wins", 1'b0, 1'b0, 1'b0);
        arm();
        press_snooze();
        chk("snooze3", bus.snoozing, 1'b1);
        bus.alarm_en = 1'b0;
        step(1);
        outs("disable_snooze", 1'b0, 1'b0, 1'b0);
        bus.now = 24'h071459;
        step(1);
        bus.alarm_en = 1'b1;
        step(1);

        // 5: wrong minute and disabled alarm never ring
        bus.alarm = 24'h071600;
        arm();
        step(2);
        outs("wrong_minute", 1'b0, 1'b0, 1'b0);
        bus.alarm    = 24'h071500;
        bus.alarm_en = 1'b0;
        arm();
        step(2);
        outs("disabled", 1'b0, 1'b0, 1'b0);
        // Enabling while the time already matches is itself a match edge
        bus.alarm_en = 1'b1;
        step(1);
        chk("enable_edge_rings", bus.ringing, 1'b1);
        tick();
        // 5: asynchronous reset mid-ring clears outputs without a clock edge
        #2;
        rst = 1'b1;
        #1;
        outs("async_rst", 1'b0, 1'b0, 1'b0);
        bus.now = 24'h071501;
        step(2);
        rst = 1'b0;
        step(3);
        outs("no_resume", 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
